// File: rtl/bus_to_sample_if.sv
// Word-side handshake for bus_to_sample: the bus buffer (master) offers 64-bit
// words, the replayer (slave) takes them when it has room.
interface bus_to_sample_if;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/bus_to_sample.sv
// Replays 64-bit words as eight parallel output bits, one byte per sample tick,
// byte 0 first, using a hold/active double buffer and a clock-enable divider.
module bus_to_sample #(
  parameter int unsigned DIV = 50
) (
  input  logic               fastclk,
  input  logic               reset,
  bus_to_sample_if.slave     bus,
  output logic               bit0,
  output logic               bit1,
  output logic               bit2,
  output logic               bit3,
  output logic               bit4,
  output logic               bit5,
  output logic               bit6,
  output logic               bit7,
  output logic               sample_strobe,
  output logic               underrun,
  output logic               busy
);

  localparam int unsigned   CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic          tick;

  logic [63:0]   hold_q;
  logic          hold_full;
  logic [63:0]   active_q;
  logic          active;
  logic [2:0]    idx;
  logic          played_once;
  logic [7:0]    sample_q;

  logic          accept;
  logic          take_hold;

  assign tick = (cnt == CNT_MAX);

  always_ff @(posedge fastclk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bus.in_ready = ~hold_full;
  assign accept       = bus.in_valid & ~hold_full;
  // Hold empties on a tick that either starts an idle block or refills at byte 7.
  assign take_hold    = tick & hold_full & (~active | (idx == 3'd7));

  always_ff @(posedge fastclk or negedge reset) begin
    if (!reset) begin
      hold_q    <= '0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_q    <= bus.in_data;
      hold_full <= 1'b1;
    end else if (take_hold) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge fastclk or negedge reset) begin
    if (!reset) begin
      active_q      <= '0;
      active        <= 1'b0;
      idx           <= '0;
      played_once   <= 1'b0;
      sample_q      <= '0;
      sample_strobe <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      sample_strobe <= 1'b0;
      underrun      <= 1'b0;
      if (tick) begin
        if (active) begin
          sample_q      <= active_q[{idx, 3'b000} +: 8];
          sample_strobe <= 1'b1;
          played_once   <= 1'b1;
          if (idx != 3'd7) begin
            idx <= idx + 3'd1;
          end else if (hold_full) begin
            active_q <= hold_q;
            idx      <= '0;
          end else begin
            active_q <= '0;
            active   <= 1'b0;
            idx      <= '0;
          end
        end else if (hold_full) begin
          // Idle start: byte 0 goes straight out of the hold word, so idx resumes at 1.
          active_q      <= hold_q;
          active        <= 1'b1;
          sample_q      <= hold_q[7:0];
          idx           <= 3'd1;
          sample_strobe <= 1'b1;
          played_once   <= 1'b1;
        end else if (played_once) begin
          underrun <= 1'b1;
        end
      end
    end
  end

  assign busy = active | hold_full;

  assign bit0 = sample_q[0];
  assign bit1 = sample_q[1];
  assign bit2 = sample_q[2];
  assign bit3 = sample_q[3];
  assign bit4 = sample_q[4];
  assign bit5 = sample_q[5];
  assign bit6 = sample_q[6];
  assign bit7 = sample_q[7];

endmodule
